// File: rtl/cache_pkg.sv
// cache_pkg: shared FSM encoding, default geometry and address-field helpers for dm_cache_responder
package cache_pkg;
  localparam int INDEX_W_DEF = 8;
  localparam int OFFS_W_DEF = 2;
  typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_e;
  function automatic logic [31:0] addr_offs(input logic [31:0] a, input int offs_w);
    return (a >> 2) & ((32'd1 << offs_w) - 32'd1);
  endfunction
  function automatic logic [31:0] addr_index(input logic [31:0] a, input int index_w, input int offs_w);
    return (a >> (offs_w + 2)) & ((32'd1 << index_w) - 32'd1);
  endfunction
  function automatic logic [31:0] addr_tag(input logic [31:0] a, input int index_w, input int offs_w);
    return a >> (index_w + offs_w + 2);
  endfunction
endpackage

// File: rtl/cache_mem_beat.sv
// cache_mem_beat: word-serial req/ack sequencer moving one cache line to or from memory
module cache_mem_beat #(
  parameter int OFFS_W = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     we,
  input  logic [29-OFFS_W:0]       line_addr,
  input  logic [(2**OFFS_W)*32-1:0] line,
  input  logic                     mem_ack,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [OFFS_W-1:0]        beat,
  output logic                     fill_we,
  output logic                     done
);
  logic busy, wr, last;
  logic [29-OFFS_W:0] line_q;
  assign last = beat == '1;
  assign done = mem_req && mem_ack && last;
  assign fill_we = mem_req && mem_ack && !mem_we;
  // latch a phase on start, then raise req one cycle later and drop it for a cycle after every ack
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      busy <= 1'b0;
      wr <= 1'b0;
      line_q <= '0;
      beat <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else if (start) begin
      busy <= 1'b1;
      wr <= we;
      line_q <= line_addr;
      beat <= '0;
      mem_req <= 1'b0;
    end else if (mem_req) begin
      if (mem_ack) begin
        mem_req <= 1'b0;
        beat <= beat + 1'b1;
        busy <= !last;
      end
    end else if (busy) begin
      mem_req <= 1'b1;
      mem_we <= wr;
      mem_addr <= {line_q, beat, 2'b00};
      mem_wdata <= line[32*beat +: 32];
    end
endmodule

// File: rtl/dm_cache_responder.sv
// dm_cache_responder: direct-mapped write-back cache with word-serial refill; CACHE_STATS_EN adds hit/miss counters
module dm_cache_responder
  import cache_pkg::*;
#(
  parameter int INDEX_W = INDEX_W_DEF,
  parameter int OFFS_W = OFFS_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_cache,
  input  logic [31:0] wdata_cache,
  input  logic        write_enable_cache,
  input  logic        read_enable_cache,
  output logic [31:0] rdata_cache,
  output logic        miss_cache,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam int TAG_W = 32 - INDEX_W - OFFS_W - 2;
  localparam int LINES = 2**INDEX_W;
  localparam int WPL = 2**OFFS_W;
  state_e state;
  logic [LINES-1:0] valid, dirty;
  logic [TAG_W-1:0] tags [LINES];
  logic [31:0] data [LINES*WPL];
  logic [TAG_W-1:0] tag, tag_q;
  logic [INDEX_W-1:0] idx, idx_q;
  logic [OFFS_W-1:0] offs, beat;
  logic req, hit, victim_dirty, start, seq_we, fill_we, done;
  logic [29-OFFS_W:0] line_addr;
  logic [WPL*32-1:0] line;
  assign offs = OFFS_W'(addr_offs(addr_cache, OFFS_W));
  assign idx = INDEX_W'(addr_index(addr_cache, INDEX_W, OFFS_W));
  assign tag = TAG_W'(addr_tag(addr_cache, INDEX_W, OFFS_W));
  assign req = read_enable_cache | write_enable_cache;
  assign hit = req && valid[idx] && tags[idx] == tag && state == IDLE;
  assign miss_cache = req && !hit;
  assign rdata_cache = data[{idx, offs}];
  assign victim_dirty = valid[idx] && dirty[idx];
  assign start = (state == IDLE && miss_cache) || (state == WB && done);
  assign seq_we = state == IDLE && victim_dirty;
  assign line_addr = state != IDLE ? {tag_q, idx_q} : victim_dirty ? {tags[idx], idx} : {tag, idx};
  for (genvar b = 0; b < WPL; b++) begin : g_line
    assign line[b*32 +: 32] = data[{idx_q, OFFS_W'(b)}];
  end
  cache_mem_beat #(.OFFS_W(OFFS_W)) u_beat (
    .clk(clk),
    .rst(rst),
    .start(start),
    .we(seq_we),
    .line_addr(line_addr),
    .line(line),
    .mem_ack(mem_ack),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .beat(beat),
    .fill_we(fill_we),
    .done(done)
  );
  // miss FSM plus valid/dirty bookkeeping; the miss target is frozen on leaving IDLE
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
      tag_q <= '0;
      idx_q <= '0;
    end else begin
      case (state)
        IDLE: if (miss_cache) state <= victim_dirty ? WB : FILL;
        WB: if (done) state <= FILL;
        FILL: if (done) state <= DONE;
        default: state <= IDLE;
      endcase
      if (state == IDLE && miss_cache) begin
        tag_q <= tag;
        idx_q <= idx;
      end
      if (hit && write_enable_cache) dirty[idx] <= 1'b1;
      if (state == FILL && done) begin
        valid[idx_q] <= 1'b1;
        dirty[idx_q] <= 1'b0;
      end
    end
  // data and tag storage survive reset; only valid bits decide what is usable
  always_ff @(posedge clk) begin
    if (hit && write_enable_cache) data[{idx, offs}] <= wdata_cache;
    if (fill_we) data[{idx_q, beat}] <= mem_rdata;
    if (state == FILL && done) tags[idx_q] <= tag_q;
  end
`ifdef CACHE_STATS_EN
  // saturating hit and miss counters
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hit_count <= '0;
      miss_count <= '0;
    end else begin
      if (hit && hit_count != '1) hit_count <= hit_count + 32'd1;
      if (state == IDLE && miss_cache && miss_count != '1) miss_count <= miss_count + 32'd1;
    end
`endif
endmodule
